dm_cache_ctrl: RTL and testbench
================================

Name: dm_cache_ctrl

Overview:
- Initiator side of the 8-set storage arrays: a direct-mapped, write-back, write-allocate cache for the test cache.
- Accepts 32-bit CPU word requests and decodes the address into tag, set index and word offset.
- Drives read and write index/load on its tag, data and dirty storage.
- Fills and evicts 256-bit lines over a req/resp handshake to physical memory.

Parameters:
- S_INDEX, 3, set-index bits (8 sets); fixed to match the 3-bit array index.
- S_OFFSET, 5, byte-offset bits within a 32-byte line.
- S_LINE, 256, line width in bits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp; mutually exclusive with mem_read
- mem_address  in  32  CPU byte address; word-aligned
- mem_wdata  in  32  CPU write data
- mem_byte_enable  in  4  write byte mask
- mem_rdata  out  32  read data, valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_address  out  32  line address, low 5 bits zero
- pmem_wdata  out  256  evicted line
- pmem_rdata  in  256  fill line, valid with pmem_resp
- pmem_resp  in  1  one-cycle memory completion
- hit_count  out  32  see Optional Feature
- miss_count  out  32  see Optional Feature

Behaviour:
- Address split: tag=[31:8], index=[7:5], word=[4:2].
- Storage:
  - Internal data store (8x256), tag store (8x24) and dirty store (8x1).
  - Write-through-bypassed read as in the team's arrays: read index = request index, combinational read, posedge write.
  - Valid bits: 8-bit flop vector, cleared by rst.
- Reset (asynchronous): state=CHECK, valid=0, all outputs 0; pmem_* deassert immediately.
- FSM:
  - CHECK:
    - Idle when no request. hit = valid[index] && tag_store[index]==tag.
    - Read hit: mem_resp=1 combinationally in the same cycle; mem_rdata = data word.
    - Write hit: mem_resp=1 the same cycle. At the edge, merge bytes per mem_byte_enable into the line and set dirty[index]=1.
    - Miss with dirty victim -> WB; miss with clean or invalid victim -> FILL.
  - WB:
    - pmem_write=1, pmem_address={old_tag,index,5'b0}, pmem_wdata = victim line.
    - On pmem_resp -> FILL.
  - FILL:
    - pmem_read=1, pmem_address={tag,index,5'b0}.
    - On pmem_resp: load data=pmem_rdata, tag=tag, valid=1, dirty=0 -> CHECK.
    - The request is then re-checked and hits, so miss latency = memory latency(s) + 1 cycle.
- mem_resp never asserts outside CHECK; a request is never acknowledged twice.
- pmem_read and pmem_write are never simultaneously high and remain stable until pmem_resp.
- A write hit updates the line whose bypass is visible on the next read to the same index the following cycle.
- mem_read and mem_write both high: undefined; the bench must not drive it.
- A request dropped mid-miss by the CPU is illegal. The controller still completes the WB/FILL and returns to CHECK.
- A pmem_resp outside WB/FILL is ignored.

Optional Feature:
- Macro CACHE_PERF_CNT_EN.
- Defined:
  - hit_count increments on every first-pass CHECK hit.
  - miss_count increments once per miss, at the CHECK->WB or CHECK->FILL transition.
  - The re-check hit after FILL is not counted.
  - Both counters are 32-bit wrapping and cleared by rst.
- Undefined: both outputs tie to 0 and no counter flops are synthesised.

Decomposition:
- Package dm_cache_pkg:
  - state enum {CHECK, WB, FILL}.
  - Constants S_TAG=24, S_INDEX=3, S_OFFSET=5, S_LINE=256, NUM_SETS=8.
  - tag_t, index_t and line_t typedefs.
- One sub-module, dm_cache_datapath: owns the stores, valid vector, byte merge, hit compare and pmem address mux; the FSM stays in the top.

Test Plan:
- Reset, then read 0x0000_0040 -> FILL with pmem_address=0x40; return line word1=0xDEADBEEF; mem_resp 1 cycle after pmem_resp, mem_rdata=0xDEADBEEF; miss_count=1.
- Repeat read 0x0000_0044 -> mem_resp same cycle, no pmem activity; hit_count=1.
- Write 0x0000_0040, wdata=0xAABBCCDD, be=4'b0011 -> same-cycle resp. Then read 0x40 -> 0xDEADCCDD.
- Read 0x0000_1040 (same index 2, new tag) -> pmem_write at 0x40 with modified line first, then pmem_read at 0x1040; pmem_read never overlaps pmem_write.
- Assert rst mid-FILL (pmem_read=1) -> pmem_read drops asynchronously, valid cleared; next read of 0x40 misses again.
- Sweep all 8 indices with clean misses, then re-read all 8 -> eight hits, zero pmem traffic.

Source files
------------

// File: rtl/dm_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_cache_pkg
//  Description : Shared types and geometry for the direct-mapped write-back
//                cache controller (8 sets x 32-byte lines, 32-bit words).
//  Revision    : 1.0 - initial release
// ============================================================================
package dm_cache_pkg;

  localparam int S_TAG    = 24;
  localparam int S_INDEX  = 3;
  localparam int S_OFFSET = 5;
  localparam int S_LINE   = 256;
  localparam int NUM_SETS = 8;

  typedef enum logic [1:0] {
    CHECK = 2'd0,
    WB    = 2'd1,
    FILL  = 2'd2
  } state_t;

  typedef logic [S_TAG-1:0]   tag_t;
  typedef logic [S_INDEX-1:0] index_t;
  typedef logic [S_LINE-1:0]  line_t;

  // Line-aligned physical address for a tag/set pair
  function automatic logic [31:0] line_addr(input tag_t tag, input index_t idx);
    return {tag, idx, {S_OFFSET{1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_cache_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : dm_cache_datapath
//  Description : Storage and steering for the direct-mapped cache: data, tag
//                and dirty stores, valid vector, byte merge for write hits,
//                hit compare and the physical-memory address/data mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_cache_datapath
  import dm_cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_be,
  input  logic        i_wr_hit,
  input  logic        i_fill_ld,
  input  line_t       i_fill_line,
  input  logic        i_sel_wb,
  input  logic        i_sel_fill,
  output logic        o_hit,
  output logic        o_victim_dirty,
  output logic [31:0] o_rdata,
  output logic [31:0] o_pmem_addr,
  output line_t       o_pmem_wdata
);

  tag_t       w_tag;
  index_t     w_index;
  logic [2:0] w_word;
  logic       w_unused;

  assign w_tag    = i_addr[31:8];
  assign w_index  = i_addr[7:5];
  assign w_word   = i_addr[4:2];
  // Requests are word aligned; the byte offset carries no information
  assign w_unused = ^i_addr[1:0];

  line_t                r_data  [NUM_SETS];
  tag_t                 r_tag   [NUM_SETS];
  logic                 r_dirty [NUM_SETS];
  logic [NUM_SETS-1:0]  r_valid;

  line_t       w_line;
  line_t       w_merged;
  logic [31:0] w_word_new;

  assign w_line         = r_data[w_index];
  assign o_hit          = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign o_victim_dirty = r_valid[w_index] && r_dirty[w_index];
  assign o_rdata        = w_line[{w_word, 5'b0} +: 32];

  // Overlay the enabled bytes of the CPU word onto the resident line
  always_comb begin
    w_word_new = w_line[{w_word, 5'b0} +: 32];
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) w_word_new[8*b +: 8] = i_wdata[8*b +: 8];
    end
    w_merged = w_line;
    w_merged[{w_word, 5'b0} +: 32] = w_word_new;
  end

  // Data/tag/dirty stores: a fill replaces the whole line, a write hit dirties it
  always_ff @(posedge clk) begin
    if (i_fill_ld) begin
      r_data[w_index]  <= i_fill_line;
      r_tag[w_index]   <= w_tag;
      r_dirty[w_index] <= 1'b0;
    end else if (i_wr_hit) begin
      r_data[w_index]  <= w_merged;
      r_dirty[w_index] <= 1'b1;
    end
  end

  // Valid bits are the only storage that must come out of reset known
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_fill_ld) begin
      r_valid[w_index] <= 1'b1;
    end
  end

  // Victim address during writeback, requested line during fill, else zero
  always_comb begin
    o_pmem_addr  = '0;
    o_pmem_wdata = '0;
    if (i_sel_wb) begin
      o_pmem_addr  = line_addr(r_tag[w_index], w_index);
      o_pmem_wdata = w_line;
    end else if (i_sel_fill) begin
      o_pmem_addr  = line_addr(w_tag, w_index);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dm_cache_ctrl
//  Description : Direct-mapped, write-back, write-allocate cache controller.
//                CPU word requests hit in CHECK with a same-cycle response;
//                misses write back a dirty victim (WB) then fill (FILL).
//                Optional hit/miss counters are enabled by defining the
//                macro CACHE_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_cache_ctrl
  import dm_cache_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  input  logic [3:0]   mem_byte_enable,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  state_t      r_state;
  logic        r_pmem_read;
  logic        r_pmem_write;

  logic        w_req;
  logic        w_hit;
  logic        w_victim_dirty;
  logic        w_resp;
  logic        w_miss_go;
  logic        w_fill_ld;
  logic [31:0] w_rdata;

  assign w_req     = mem_read | mem_write;
  assign w_resp    = (r_state == CHECK) && w_req && w_hit;
  assign w_miss_go = (r_state == CHECK) && w_req && !w_hit;
  assign w_fill_ld = (r_state == FILL) && pmem_resp;

  assign mem_resp   = w_resp;
  assign mem_rdata  = w_resp ? w_rdata : '0;
  assign pmem_read  = r_pmem_read;
  assign pmem_write = r_pmem_write;

  dm_cache_datapath u_datapath (
    .clk            (clk),
    .rst            (rst),
    .i_addr         (mem_address),
    .i_wdata        (mem_wdata),
    .i_be           (mem_byte_enable),
    .i_wr_hit       (w_resp & mem_write),
    .i_fill_ld      (w_fill_ld),
    .i_fill_line    (pmem_rdata),
    .i_sel_wb       (r_pmem_write),
    .i_sel_fill     (r_pmem_read),
    .o_hit          (w_hit),
    .o_victim_dirty (w_victim_dirty),
    .o_rdata        (w_rdata),
    .o_pmem_addr    (pmem_address),
    .o_pmem_wdata   (pmem_wdata)
  );

  // Miss sequencing; pmem strobes are registered so they change only on state moves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= CHECK;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
    end else begin
      case (r_state)
        CHECK: begin
          if (w_miss_go) begin
            if (w_victim_dirty) begin
              r_state      <= WB;
              r_pmem_write <= 1'b1;
            end else begin
              r_state      <= FILL;
              r_pmem_read  <= 1'b1;
            end
          end
        end
        WB: begin
          if (pmem_resp) begin
            r_state      <= FILL;
            r_pmem_write <= 1'b0;
            r_pmem_read  <= 1'b1;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            r_state     <= CHECK;
            r_pmem_read <= 1'b0;
          end
        end
        default: begin
          r_state      <= CHECK;
          r_pmem_read  <= 1'b0;
          r_pmem_write <= 1'b0;
        end
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic        r_recheck;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // r_recheck marks the first CHECK cycle after a fill so its hit is not counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_recheck  <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_fill_ld) begin
        r_recheck <= 1'b1;
      end else if (r_state == CHECK) begin
        r_recheck <= 1'b0;
      end
      if (w_resp && !r_recheck) r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss_go)            r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_cache_ctrl
//  Description : Self-checking bench for dm_cache_ctrl: a word-level golden
//                memory plus a set/tag/dirty model predicts hits, writebacks,
//                fills and read data; a randomized-latency memory responder
//                serves the pmem port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address, mem_wdata;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  hit_count, miss_count;

  always #5 clk = ~clk;

  dm_cache_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- physical memory and golden CPU view ----------------
  logic [31:0] memw [int unsigned];
  logic [31:0] gold [int unsigned];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (memw.exists(a)) return memw[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] gold_word(input logic [31:0] a);
    if (gold.exists(a)) return gold[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef CACHE_PERF_CNT_EN
    return n;
`else
    return (n == -1) ? 32'd1 : 32'd0;
`endif
  endfunction

  // ---------------- pmem responder with logging ----------------
  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
    int unsigned  c;
  } ptxn_t;

  ptxn_t plog[$];
  bit    mem_stall   = 1'b0;
  int    stab_err    = 0;
  int    overlap_err = 0;

  always @(negedge clk) if (pmem_read && pmem_write) overlap_err++;

  initial begin
    ptxn_t t;
    int    lat, n;
    bit    abort;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && (pmem_read || pmem_write)) begin
        t.wr   = pmem_write;
        t.addr = pmem_address;
        t.data = pmem_wdata;
        t.c    = 0;
        lat    = $urandom_range(1, 4);
        n      = 1;
        abort  = 1'b0;
        while (n < lat || mem_stall) begin
          @(negedge clk);
          if (rst || !(pmem_read || pmem_write)) begin
            abort = 1'b1;
            break;
          end
          if (pmem_write !== t.wr || pmem_address !== t.addr ||
              (t.wr && pmem_wdata !== t.data)) stab_err++;
          n++;
        end
        if (!abort) begin
          t.c = cyc;
          if (t.wr) begin
            for (int w = 0; w < 8; w++) memw[t.addr + 4*w] = t.data[32*w +: 32];
          end else begin
            for (int w = 0; w < 8; w++) pmem_rdata[32*w +: 32] = mem_word(t.addr + 4*w);
          end
          plog.push_back(t);
          pmem_resp = 1'b1;
          @(negedge clk);
          pmem_resp = 1'b0;
        end
      end
    end
  end

  // ---------------- CPU driver ----------------
  logic [31:0] obs_rdata;
  int unsigned obs_cyc, obs_start;
  bit          obs_to;

  task automatic cpu_access(input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
    plog.delete();
    @(posedge clk); #1;
    mem_read        = !wr;
    mem_write       = wr;
    mem_address     = a;
    mem_wdata       = wd;
    mem_byte_enable = be;
    obs_start       = cyc;
    obs_to          = 1'b1;
    obs_rdata       = '0;
    obs_cyc         = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mem_resp) begin
        obs_rdata = mem_rdata;
        obs_cyc   = cyc;
        obs_to    = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // ---------------- reference cache model ----------------
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [23:0]  m_tag   [8];
  bit           e_hit, e_wb;
  logic [31:0]  e_wb_addr, e_fill_addr, e_rdata;
  logic [255:0] e_wb_data;
  int           e_hits = 0, e_misses = 0;

  task automatic model_reset;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    e_hits   = 0;
    e_misses = 0;
  endtask

  task automatic model_access(input bit wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] be);
    int          s;
    logic [23:0] tg;
    logic [31:0] wa, w;
    s  = int'(a[7:5]);
    tg = a[31:8];
    wa = {a[31:2], 2'b00};
    e_hit       = m_valid[s] && (m_tag[s] == tg);
    e_wb        = !e_hit && m_valid[s] && m_dirty[s];
    e_wb_addr   = {m_tag[s], a[7:5], 5'b0};
    e_fill_addr = {tg, a[7:5], 5'b0};
    for (int i = 0; i < 8; i++) e_wb_data[32*i +: 32] = gold_word(e_wb_addr + 4*i);
    if (e_hit) e_hits++; else e_misses++;
    if (!e_hit) m_dirty[s] = 1'b0;
    m_valid[s] = 1'b1;
    m_tag[s]   = tg;
    w = gold_word(wa);
    if (wr) begin
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      gold[wa]   = w;
      m_dirty[s] = 1'b1;
    end
    e_rdata = w;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0 ||
        pmem_address !== 32'h0 || mem_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: resp=%b prd=%b pwr=%b paddr=%h rdata=%h, required all zero",
               mem_resp, pmem_read, pmem_write, pmem_address, mem_rdata);
    end
    total++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      bad++;
      $display("FAIL reset_counters: hit=%0d miss=%0d, required 0/0", hit_count, miss_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fill;
    model_access(1'b0, 32'h40, '0, 4'h0);
    cpu_access(1'b0, 32'h40, '0, 4'h0);
    total++;
    if (obs_to || plog.size() != 1 || plog[0].wr || plog[0].addr !== 32'h40) begin
      bad++;
      $display("FAIL fill_traffic: timeout=%b ntxn=%0d, required one read at 00000040",
               obs_to, plog.size());
    end
    total++;
    if (obs_rdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL fill_rdata: got %h required deadbeef", obs_rdata);
    end
    total++;
    if (plog.size() < 1 || obs_cyc != plog[plog.size()-1].c + 1) begin
      bad++;
      $display("FAIL fill_latency: resp cycle %0d, required one cycle after pmem_resp", obs_cyc);
    end
    total++;
    if (miss_count !== exp_cnt(1) || hit_count !== exp_cnt(0)) begin
      bad++;
      $display("FAIL fill_counters: hit=%0d miss=%0d required %0d/%0d",
               hit_count, miss_count, exp_cnt(0), exp_cnt(1));
    end
  endtask

  task automatic test_hit;
    model_access(1'b0, 32'h44, '0, 4'h0);
    cpu_access(1'b0, 32'h44, '0, 4'h0);
    total++;
    if (obs_to || plog.size() != 0 || obs_cyc != obs_start || obs_rdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL read_hit: timeout=%b ntxn=%0d lat=%0d rdata=%h, required same-cycle deadbeef",
               obs_to, plog.size(), obs_cyc - obs_start, obs_rdata);
    end
    total++;
    if (hit_count !== exp_cnt(1)) begin
      bad++;
      $display("FAIL hit_count: got %0d required %0d", hit_count, exp_cnt(1));
    end
  endtask

  task automatic test_write_hit;
    model_access(1'b1, 32'h40, 32'hAABB_CCDD, 4'b0011);
    cpu_access(1'b1, 32'h40, 32'hAABB_CCDD, 4'b0011);
    total++;
    if (obs_to || plog.size() != 0 || obs_cyc != obs_start) begin
      bad++;
      $display("FAIL write_hit: timeout=%b ntxn=%0d lat=%0d, required same-cycle no traffic",
               obs_to, plog.size(), obs_cyc - obs_start);
    end
    model_access(1'b0, 32'h40, '0, 4'h0);
    cpu_access(1'b0, 32'h40, '0, 4'h0);
    total++;
    if (obs_rdata !== 32'hDEAD_CCDD || obs_rdata !== e_rdata) begin
      bad++;
      $display("FAIL write_merge: got %h required deadccdd", obs_rdata);
    end
  endtask

  task automatic test_evict;
    model_access(1'b0, 32'h1040, '0, 4'h0);
    cpu_access(1'b0, 32'h1040, '0, 4'h0);
    total++;
    if (obs_to || plog.size() != 2 || !plog[0].wr || plog[0].addr !== 32'h40 ||
        plog[0].data !== e_wb_data || plog[0].data[31:0] !== 32'hDEAD_CCDD) begin
      bad++;
      $display("FAIL evict_wb: timeout=%b ntxn=%0d, required writeback of dirty line at 00000040 first",
               obs_to, plog.size());
    end
    total++;
    if (plog.size() != 2 || plog[1].wr || plog[1].addr !== 32'h1040 || obs_rdata !== e_rdata) begin
      bad++;
      $display("FAIL evict_fill: rdata=%h required %h with fill at 00001040", obs_rdata, e_rdata);
    end
    total++;
    if (overlap_err != 0) begin
      bad++;
      $display("FAIL pmem_overlap: %0d cycles with read and write high, required 0", overlap_err);
    end
  endtask

  task automatic test_reset_mid_fill;
    bit seen;
    mem_stall = 1'b1;
    @(posedge clk); #1;
    mem_read    = 1'b1;
    mem_address = 32'h80;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pmem_read) begin
        seen = 1'b1;
        break;
      end
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (!seen || pmem_read !== 1'b0 || pmem_address !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_fill: fill_seen=%b pmem_read=%b paddr=%h, required fill then async drop",
               seen, pmem_read, pmem_address);
    end
    mem_read  = 1'b0;
    mem_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    total++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_fill_counters: hit=%0d miss=%0d required 0/0", hit_count, miss_count);
    end
    model_access(1'b0, 32'h40, '0, 4'h0);
    cpu_access(1'b0, 32'h40, '0, 4'h0);
    total++;
    if (obs_to || plog.size() != 1 || plog[0].wr || plog[0].addr !== 32'h40 ||
        obs_rdata !== 32'hDEAD_CCDD) begin
      bad++;
      $display("FAIL post_reset_miss: timeout=%b ntxn=%0d rdata=%h, required refill of 00000040 -> deadccdd",
               obs_to, plog.size(), obs_rdata);
    end
  endtask

  task automatic test_sweep;
    logic [31:0] a;
    int          traffic;
    for (int i = 0; i < 8; i++) begin
      a = 32'h3000 + 32'(i * 32) + 32'(4 * ((i * 3) % 8));
      model_access(1'b0, a, '0, 4'h0);
      cpu_access(1'b0, a, '0, 4'h0);
      total++;
      if (obs_to || e_hit || e_wb || plog.size() != 1 || plog[0].wr ||
          plog[0].addr !== e_fill_addr || obs_rdata !== e_rdata) begin
        bad++;
        $display("FAIL sweep_miss[%0d]: ntxn=%0d rdata=%h required clean fill of %h -> %h",
                 i, plog.size(), obs_rdata, e_fill_addr, e_rdata);
      end
    end
    traffic = 0;
    for (int i = 0; i < 8; i++) begin
      a = 32'h3000 + 32'(i * 32) + 32'(4 * ((i * 5) % 8));
      model_access(1'b0, a, '0, 4'h0);
      cpu_access(1'b0, a, '0, 4'h0);
      traffic += plog.size();
      total++;
      if (obs_to || obs_cyc != obs_start || obs_rdata !== e_rdata) begin
        bad++;
        $display("FAIL sweep_hit[%0d]: lat=%0d rdata=%h required same-cycle %h",
                 i, obs_cyc - obs_start, obs_rdata, e_rdata);
      end
    end
    total++;
    if (traffic != 0) begin
      bad++;
      $display("FAIL sweep_traffic: %0d pmem transactions on re-read, required 0", traffic);
    end
  endtask

  task automatic test_random;
    bit          wr;
    logic [31:0] a, wd;
    logic [3:0]  be;
    int          exp_n;
    for (int it = 0; it < 200; it++) begin
      wr = 1'($urandom_range(0, 1));
      a  = {22'($urandom_range(0, 3)), 2'b00, 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 2'b00};
      wd = $urandom;
      be = 4'($urandom_range(1, 15));
      model_access(wr, a, wd, be);
      cpu_access(wr, a, wd, be);
      exp_n = e_hit ? 0 : (e_wb ? 2 : 1);
      total++;
      if (obs_to || plog.size() != exp_n ||
          (e_wb && (!plog[0].wr || plog[0].addr !== e_wb_addr || plog[0].data !== e_wb_data)) ||
          (exp_n > 0 && (plog[exp_n-1].wr || plog[exp_n-1].addr !== e_fill_addr))) begin
        bad++;
        $display("FAIL rand_traffic[%0d]: addr=%h timeout=%b ntxn=%0d, required %0d (wb=%b fill=%h)",
                 it, a, obs_to, plog.size(), exp_n, e_wb, e_fill_addr);
      end
      total++;
      if (e_hit ? (obs_cyc != obs_start)
                : (plog.size() == 0 || obs_cyc != plog[plog.size()-1].c + 1)) begin
        bad++;
        $display("FAIL rand_latency[%0d]: addr=%h resp cycle %0d start %0d, hit=%b",
                 it, a, obs_cyc, obs_start, e_hit);
      end
      if (!wr) begin
        total++;
        if (obs_rdata !== e_rdata) begin
          bad++;
          $display("FAIL rand_rdata[%0d]: addr=%h got %h required %h", it, a, obs_rdata, e_rdata);
        end
      end
    end
  endtask

  task automatic test_final;
    @(negedge clk);
    total++;
    if (hit_count !== exp_cnt(e_hits) || miss_count !== exp_cnt(e_misses)) begin
      bad++;
      $display("FAIL final_counters: hit=%0d miss=%0d required %0d/%0d",
               hit_count, miss_count, exp_cnt(e_hits), exp_cnt(e_misses));
    end
    total++;
    if (stab_err != 0 || overlap_err != 0) begin
      bad++;
      $display("FAIL pmem_protocol: unstable=%0d overlap=%0d, required 0/0", stab_err, overlap_err);
    end
  endtask

  initial begin
    rst             = 1'b1;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
    memw[32'h40] = 32'hDEAD_BEEF;
    memw[32'h44] = 32'hDEAD_BEEF;
    gold[32'h40] = 32'hDEAD_BEEF;
    gold[32'h44] = 32'hDEAD_BEEF;
    test_reset();
    test_fill();
    test_hit();
    test_write_hit();
    test_evict();
    test_reset_mid_fill();
    test_sweep();
    test_random();
    test_final();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
